// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single port of the unified code/data memory.
// Grants are combinational; read data is routed back one cycle later to the issuer.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int FAIR     = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          a_valid,
  input  logic          a_write,
  input  logic [3:0]    a_wmask,
  input  logic [31:0]   a_wdata,
  input  logic [AW-1:0] a_addr,
  output logic          a_ready,
  output logic          a_rvalid,
  output logic [31:0]   a_rdata,
  input  logic          b_valid,
  input  logic          b_write,
  input  logic [3:0]    b_wmask,
  input  logic [31:0]   b_wdata,
  input  logic [AW-1:0] b_addr,
  output logic          b_ready,
  output logic          b_rvalid,
  output logic [31:0]   b_rdata,
  output logic          mem_valid,
  output logic          mem_write,
  output logic [3:0]    mem_wmask,
  output logic [31:0]   mem_wdata,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata
);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  logic [7:0] starve_q, starve_d;
  logic       last_b_q, last_b_d;
  logic       rpend_q, rpend_d;
  logic       rsel_q, rsel_d;
  logic       b_wins_tie, grant_a, grant_b;

  // rstn gates the grants so nothing reaches memory while reset is held.
  always_comb begin
    b_wins_tie = (FAIR != 0) ? !last_b_q : (starve_q == MaxWait);
    grant_b    = rstn & b_valid & (!a_valid | b_wins_tie);
    grant_a    = rstn & a_valid & !grant_b;
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign mem_valid = grant_a | grant_b;

  always_comb begin
    mem_write = 1'b0;
    mem_wmask = 4'h0;
    mem_wdata = 32'h0;
    mem_addr  = '0;
    if (grant_a) begin
      mem_write = a_write;
      mem_wmask = a_wmask;
      mem_wdata = a_wdata;
      mem_addr  = a_addr;
    end else if (grant_b) begin
      mem_write = b_write;
      mem_wmask = b_wmask;
      mem_wdata = b_wdata;
      mem_addr  = b_addr;
    end
  end

  always_comb begin
    starve_d = 8'd0;
    if (b_valid && !grant_b) begin
      starve_d = (starve_q == MaxWait) ? starve_q : starve_q + 8'd1;
    end

    last_b_d = last_b_q;
    if (grant_a) begin
      last_b_d = 1'b0;
    end else if (grant_b) begin
      last_b_d = 1'b1;
    end

    rpend_d = (grant_a & !a_write) | (grant_b & !b_write);
    rsel_d  = rpend_d ? grant_b : rsel_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_q <= 8'd0;
      last_b_q <= 1'b1;
      rpend_q  <= 1'b0;
      rsel_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      last_b_q <= last_b_d;
      rpend_q  <= rpend_d;
      rsel_q   <= rsel_d;
    end
  end

  assign a_rvalid = rpend_q & !rsel_q;
  assign b_rvalid = rpend_q & rsel_q;
  assign a_rdata  = mem_rdata;
  assign b_rdata  = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 32-bit port of the unified code/data memory between two requesters: port A (pipeline) and port B (debug loader / DMA, e.g. host-side program load or result dump).
- Sits between the requesters and the memory.
- Drives the memory's valid/write/wmask/wdata/addr signals and routes the 1-cycle-latency read data back to the requester that issued the read.
- Arbitration is fixed-priority A with a starvation guard for B, or round-robin, selected by parameter.

Parameters:
- AW, 32, address width of both request ports and the memory address output.
- FAIR, 0, arbitration mode: 0 = A priority with B starvation guard; 1 = strict round-robin.
- MAX_WAIT, 4, FAIR=0 only: consecutive cycles B may wait before it is forced a grant. Legal range 1..255.

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- a_valid  in  1  port A request
- a_write  in  1  port A write (0 = read)
- a_wmask  in  4  port A byte enables
- a_wdata  in  32  port A write data
- a_addr  in  AW  port A byte address
- a_ready  out  1  port A request accepted this cycle
- a_rvalid  out  1  port A read data valid
- a_rdata  out  32  port A read data
- b_valid, b_write, b_wmask, b_wdata, b_addr, b_ready, b_rvalid, b_rdata: as port A, for port B
- mem_valid  out  1  memory access this cycle
- mem_write  out  1  memory write
- mem_wmask  out  4  memory byte enables
- mem_wdata  out  32  memory write data
- mem_addr  out  AW  memory byte address
- mem_rdata  in  32  memory read data, valid 1 cycle after a read access

Behaviour:
- Requesters hold valid and all request fields stable until ready; a request is accepted in the cycle where valid & ready.
- Grant is combinational in the same cycle from the valid inputs and registered state. At most one of a_ready/b_ready is high per cycle; ready is never high without its valid.
- mem_valid = a_ready | b_ready. mem_write/wmask/wdata/addr are muxed from the granted port; when neither port is granted they are all 0.
- Only A valid: grant A. Only B valid: grant B. No back-to-back penalty; 100% throughput.
- Both valid, FAIR=0:
  - grant B if starve_cnt == MAX_WAIT, else grant A.
  - starve_cnt (8 bit) increments, saturating at MAX_WAIT, when b_valid & !b_ready.
  - starve_cnt clears when b_ready or !b_valid.
- Both valid, FAIR=1:
  - grant the port not granted most recently; register last_b holds 1 if the last grant went to B.
  - last_b updates on every grant; initial value after reset is 1, so A wins the first tie.
- Read return:
  - registers rpend (1 bit) and rsel (0 = A, 1 = B) are loaded on each accepted read; rpend clears when the next cycle has no accepted read.
  - x_rvalid = rpend & (rsel == x).
  - a_rdata and b_rdata both equal mem_rdata (unqualified data); consumers qualify with rvalid.
  - Writes never produce rvalid.
  - Back-to-back reads alternating A,B,A return rvalid A,B,A on the following three cycles.
- Simultaneous events:
  - A return (rvalid) and a new B grant in the same cycle is legal and independent.
  - A request on a port in the cycle its rvalid is high is legal.
- Reset (rstn low, asynchronous):
  - starve_cnt=0, last_b=1, rpend=0, rsel=0, all rvalid=0.
  - All ready and mem_* outputs are forced to 0 while rstn is low.
  - Reset mid-read discards the pending response: no rvalid after release.
- No combinational path from mem_rdata to any ready or mem_* output.

Test Plan:
- Reset: rstn=0 with a_valid=b_valid=1 → all ready, mem_valid, rvalid = 0. Release rstn → A granted first cycle (both modes).
- Single-port read: A reads 0x00000100 while memory holds 0xDEADBEEF there → a_ready in cycle N, a_rvalid=1 and a_rdata=0xDEADBEEF in N+1, b_rvalid stays 0.
- Starvation guard, FAIR=0, MAX_WAIT=4: A and B both valid continuously → grant sequence A,A,A,A,B, repeating. B write of 0x03 mask 0x1 to 0x10001000 appears on mem_* exactly on the B grant cycles.
- Round-robin, FAIR=1: both valid continuously for 6 cycles → grants A,B,A,B,A,B. Interleaved reads produce rvalid A,B,A,B,A,B one cycle later with the matching data.
- Write has no return: B writes 0x12345678 mask 0xF to 0x00001000 → b_ready one cycle, no b_rvalid. A later read of 0x00001000 by A returns 0x12345678.
- Reset mid-read: B read accepted, rstn pulsed low before the next rising edge → no b_rvalid after release; starve_cnt=0 and the first tie goes to A.
